// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the framed byte-stream memory loader.
// Frame: sync byte, start address, length (0 = 256), data bytes, additive checksum.
package mem_loader_pkg;

    localparam int unsigned AW = 8;
    localparam logic [AW-1:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM
    } state_e;

endpackage

// File: rtl/mem_loader.sv
// Parses a framed byte stream and writes the payload into a 256x8 memory.
// Writes land one cycle after the data handshake; in_ready depends on state only.
module mem_loader
    import mem_loader_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [AW-1:0] in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_d_i,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] csum_q, csum_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW-1:0] wdat_q, wdat_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          hs;

    assign in_ready = (state_q != ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign hs       = in_valid & in_ready;

    assign mem_we   = we_q;
    assign mem_addr = waddr_q;
    assign mem_d_i  = wdat_q;
    assign done     = done_q;
    assign err      = err_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdat_d  = wdat_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (hs && in_data == SYNC_BYTE) begin
                    state_d = ST_ADDR;
                    csum_d  = '0;
                end
            end
            ST_ADDR: begin
                if (hs) begin
                    ptr_d   = in_data;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (hs) begin
                    cnt_d   = in_data;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (hs) begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q;
                    wdat_d  = in_data;
                    csum_d  = csum_q + in_data;
                    ptr_d   = ptr_q + 8'd1;
                    // A loaded count of 0 decrements through 0xFF, giving 256 bytes.
                    cnt_d   = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (hs) begin
                    state_d = ST_IDLE;
                    if (in_data == csum_q) done_d = 1'b1;
                    else                   err_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdat_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdat_q  <= wdat_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a behavioural 256x8 memory on the write port.
module tb_mem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, mem_we, busy, done, err;
    logic [7:0] mem_addr, mem_d_i;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [256];
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic both_hi = 1'b0;
    int base_wr, base_done, base_err, bad;

    mem_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_d_i  (mem_d_i),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_d_i;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
        if (done && err) both_hi <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic snap();
        base_wr   = wr_cnt;
        base_done = done_cnt;
        base_err  = err_cnt;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_we",    {31'd0, mem_we},  32'd0);
        check("rst_addr",  {24'd0, mem_addr}, 32'd0);
        check("rst_busy",  {31'd0, busy},    32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", {31'd0, in_ready}, 32'd0);

        // Basic load
        snap();
        do_start();
        check("sync_busy", {31'd0, busy}, 32'd1);
        send(8'hA5); send(8'h10);
        check("addr_no_we", {31'd0, mem_we}, 32'd0);
        send(8'h03);
        check("len_no_we", {31'd0, mem_we}, 32'd0);
        send(8'h11);
        check("lat_we",   {31'd0, mem_we},  32'd1);
        check("lat_addr", {24'd0, mem_addr}, 32'h10);
        check("lat_data", {24'd0, mem_d_i},  32'h11);
        send(8'h22); send(8'h33); send(8'h66);
        check("basic_done_pulse", {30'd0, done, err}, 32'b10);
        check("basic_busy", {31'd0, busy}, 32'd0);
        gap(1);
        check("basic_done_low", {31'd0, done}, 32'd0);
        gap(1);
        check("basic_m10", {24'd0, mem[8'h10]}, 32'h11);
        check("basic_m11", {24'd0, mem[8'h11]}, 32'h22);
        check("basic_m12", {24'd0, mem[8'h12]}, 32'h33);
        check("basic_wr",   wr_cnt - base_wr,     32'd3);
        check("basic_done", done_cnt - base_done, 32'd1);

        // Checksum error
        snap();
        do_start();
        send(8'hA5); send(8'h00); send(8'h01); send(8'h3C); send(8'h00);
        check("cerr_pulse", {30'd0, done, err}, 32'b01);
        gap(2);
        check("cerr_m00", {24'd0, mem[8'h00]}, 32'h3C);
        check("cerr_err",  err_cnt - base_err,   32'd1);
        check("cerr_done", done_cnt - base_done, 32'd0);

        // Wrap-around
        snap();
        do_start();
        send(8'hA5); send(8'hFE); send(8'h03);
        send(8'h01); send(8'h02); send(8'h03); send(8'h06);
        gap(2);
        check("wrap_mFE", {24'd0, mem[8'hFE]}, 32'h01);
        check("wrap_mFF", {24'd0, mem[8'hFF]}, 32'h02);
        check("wrap_m00", {24'd0, mem[8'h00]}, 32'h03);
        check("wrap_wr",   wr_cnt - base_wr,     32'd3);
        check("wrap_done", done_cnt - base_done, 32'd1);

        // Sync hunt with stalls
        snap();
        do_start();
        send(8'h00); gap($urandom_range(1, 3));
        send(8'hFF); gap($urandom_range(1, 3));
        check("hunt_no_wr", wr_cnt - base_wr, 32'd0);
        send(8'hA5); gap($urandom_range(1, 3));
        send(8'h20); gap($urandom_range(1, 3));
        send(8'h01); gap($urandom_range(1, 3));
        send(8'hAA); gap(3);
        check("hunt_busy_stall", {31'd0, busy}, 32'd1);
        send(8'hAA); gap(2);
        check("hunt_m20",  {24'd0, mem[8'h20]}, 32'hAA);
        check("hunt_wr",   wr_cnt - base_wr,     32'd1);
        check("hunt_done", done_cnt - base_done, 32'd1);
        check("hunt_err",  err_cnt - base_err,   32'd0);

        // Reset mid-DATA, cancelling the pending write of the second byte
        mem[8'h41] = 8'h00;
        mem[8'h42] = 8'h00;
        snap();
        do_start();
        send(8'hA5); send(8'h40); send(8'h04); send(8'h5A); send(8'h6B);
        check("mid_we_pending", {31'd0, mem_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_we_cleared", {31'd0, mem_we}, 32'd0);
        check("mid_busy",       {31'd0, busy},   32'd0);
        check("mid_addr",       {24'd0, mem_addr}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        send(8'h7C); send(8'h8D);
        check("mid_ready", {31'd0, in_ready}, 32'd0);
        gap(2);
        check("mid_wr",  wr_cnt - base_wr,     32'd1);
        check("mid_m41", {24'd0, mem[8'h41]},  32'h00);
        check("mid_m42", {24'd0, mem[8'h42]},  32'h00);

        // Length 0 means 256 bytes
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        snap();
        do_start();
        send(8'hA5); send(8'h00); send(8'h00);
        for (int i = 0; i < 256; i++) send(8'(i));
        check("len0_busy_csum", {31'd0, busy}, 32'd1);
        send(8'h80);
        check("len0_pulse", {30'd0, done, err}, 32'b10);
        gap(2);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 8'(i)) bad++;
        check("len0_contents", bad, 32'd0);
        check("len0_wr",   wr_cnt - base_wr,     32'd256);
        check("len0_done", done_cnt - base_done, 32'd1);

        check("never_done_and_err", {31'd0, both_hi}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
